// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame arbiter.
//   state_e        frame FSM states
//   SYNC_BYTE_DEF  default frame start marker
//   payload_bytes  bytes needed to carry a payload of the given bit width
package serial_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StId,
      StData,
      StCsum
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   function automatic int unsigned payload_bytes(input int unsigned bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after rr_ptr, wrapping.
//   req          in   NUM_REQ  request vector
//   rr_ptr       in   IDX_W    highest-priority requester index
//   grant        out  NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx    out  IDX_W    index of the granted requester
//   grant_valid  out  1        at least one request is set
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   always_comb begin
      int unsigned cand;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      // Scan priority order ptr, ptr+1, ... and compare against fixed indices so
      // every select stays constant after unrolling.
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req[k] && (cand == k)) begin
               grant_valid = 1'b1;
               grant[k]    = 1'b1;
               grant_idx   = IDX_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/serial_frame_arbiter.sv
// Shares one byte UART among NUM_REQ payload requesters. A round-robin winner has
// its payload latched and is sent as SYNC, ID, payload bytes (LSB first), XOR checksum.
//   clock     in   1                     system clock
//   reset     in   1                     synchronous, active-high
//   req       in   NUM_REQ               level request per requester
//   payload   in   NUM_REQ*PAYLOAD_BITS  requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   ack       out  NUM_REQ               one-hot pulse: payload latched
//   done      out  1                     pulse when checksum byte is accepted
//   busy      out  1                     frame in progress
//   tx_byte   out  8                     byte to UART
//   tx_valid  out  1                     tx_byte valid
//   tx_ready  in   1                     UART accepts on tx_valid && tx_ready
module serial_frame_arbiter
   import serial_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned PAYLOAD_BITS = 162,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] payload,
   output logic [NUM_REQ-1:0]              ack,
   output logic                            done,
   output logic                            busy,
   output logic [7:0]                      tx_byte,
   output logic                            tx_valid,
   input  logic                            tx_ready
);

   localparam int unsigned PAYLOAD_BYTES = payload_bytes(PAYLOAD_BITS);
   localparam int unsigned PAD_BITS      = PAYLOAD_BYTES * 8;
   localparam int unsigned BIDX_W        = $clog2(PAYLOAD_BYTES + 1);
   localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [IDX_W-1:0]     gidx_q;
   logic [BIDX_W-1:0]    byte_idx_q;
   logic [7:0]           csum_q;
   logic [PAD_BITS-1:0]  latched_q;

   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_valid;
   logic [PAD_BITS-1:0]  latched_d;
   logic [BIDX_W-1:0]    sel_idx;
   logic [7:0]           sel_byte;
   logic [7:0]           id_byte;
   logic [IDX_W-1:0]     rr_next;
   logic                 accept;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req         (req),
      .rr_ptr      (rr_ptr_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign accept  = tx_valid && tx_ready;
   assign id_byte = 8'(gidx_q);

   // Upper pad bits of the last payload byte are forced to zero here.
   always_comb begin
      latched_d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (int'(grant_idx) == k) begin
            latched_d[PAYLOAD_BITS-1:0] = payload[k*PAYLOAD_BITS +: PAYLOAD_BITS];
         end
      end
   end

   // Byte to present after the current accept: byte 0 when leaving ID, else the next one.
   always_comb begin
      sel_idx  = (state_q == StData) ? byte_idx_q + BIDX_W'(1) : '0;
      sel_byte = '0;
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
         if (int'(sel_idx) == k) sel_byte = latched_q[k*8 +: 8];
      end
   end

   always_comb begin
      rr_next = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + IDX_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         gidx_q     <= '0;
         byte_idx_q <= '0;
         csum_q     <= '0;
         latched_q  <= '0;
         ack        <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         tx_byte    <= '0;
         tx_valid   <= 1'b0;
      end else begin
         ack  <= '0;
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               tx_valid <= 1'b0;
               if (grant_valid) begin
                  latched_q  <= latched_d;
                  gidx_q     <= grant_idx;
                  ack        <= grant;
                  busy       <= 1'b1;
                  byte_idx_q <= '0;
                  csum_q     <= '0;
                  tx_byte    <= SYNC_BYTE;
                  tx_valid   <= 1'b1;
                  state_q    <= StSync;
               end
            end
            StSync: begin
               if (accept) begin
                  tx_byte <= id_byte;
                  state_q <= StId;
               end
            end
            StId: begin
               if (accept) begin
                  csum_q  <= csum_q ^ tx_byte;
                  tx_byte <= sel_byte;
                  state_q <= StData;
               end
            end
            StData: begin
               if (accept) begin
                  csum_q     <= csum_q ^ tx_byte;
                  byte_idx_q <= byte_idx_q + BIDX_W'(1);
                  if (byte_idx_q == BIDX_W'(PAYLOAD_BYTES - 1)) begin
                     tx_byte <= csum_q ^ tx_byte;
                     state_q <= StCsum;
                  end else begin
                     tx_byte <= sel_byte;
                  end
               end
            end
            StCsum: begin
               if (accept) begin
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  tx_valid <= 1'b0;
                  tx_byte  <= '0;
                  rr_ptr_q <= rr_next;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: directed scenarios plus a randomized tail, checked
// against a frame model built from the payload and a round-robin pointer.
module tb_serial_frame_arbiter;

   localparam int NR    = 2;
   localparam int PB    = 162;
   localparam int NB    = 21;
   localparam int FRAME = NB + 3;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic [NR-1:0]       req = '0;
   logic [PB-1:0]       pl0 = '0;
   logic [PB-1:0]       pl1 = '0;
   logic [NR*PB-1:0]    payload;
   logic [NR-1:0]       ack;
   logic                done;
   logic                busy;
   logic [7:0]          tx_byte;
   logic                tx_valid;
   logic                tx_ready = 1'b0;

   int                  checks = 0;
   int                  errors = 0;
   int                  model_ptr = 0;
   logic [7:0]          exp_q[$];

   assign payload = {pl1, pl0};

   serial_frame_arbiter #(
      .NUM_REQ      (NR),
      .PAYLOAD_BITS (PB),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .payload  (payload),
      .ack      (ack),
      .done     (done),
      .busy     (busy),
      .tx_byte  (tx_byte),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant(input logic [NR-1:0] mask);
      for (int i = 0; i < NR; i++) begin
         int c;
         c = (model_ptr + i) % NR;
         if (mask[c]) return c;
      end
      return 0;
   endfunction

   function automatic logic [PB-1:0] get_pl(input int g);
      return (g == 0) ? pl0 : pl1;
   endfunction

   function automatic logic [PB-1:0] rand_pl();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[PB-1:0];
   endfunction

   // Expected frame: SYNC, ID, payload bytes LSB first (zero padded), XOR of ID and payload.
   task automatic build_exp(input int g, input logic [PB-1:0] p);
      logic [NB*8-1:0] pp;
      logic [7:0]      cs;
      pp = '0;
      pp[PB-1:0] = p;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(g));
      cs = 8'(g);
      for (int k = 0; k < NB; k++) begin
         exp_q.push_back(pp[k*8 +: 8]);
         cs = cs ^ pp[k*8 +: 8];
      end
      exp_q.push_back(cs);
   endtask

   // Called at a negedge with the DUT idle; raises mask, follows one frame to its done.
   task automatic run_frame(input logic [NR-1:0] mask, input int duty, input bit keep_req,
                            input logic [NR-1:0] mid_mask);
      int         g;
      int         idx;
      int         cyc;
      bit         stalled;
      bit         rdy;
      logic [7:0] prev;
      g   = exp_grant(mask);
      req = mask;
      @(negedge clock);
      check("ack_grant", 64'(ack), 64'(1 << g));
      check("done_single", 64'(done), 64'(0));
      check("busy_at_ack", 64'(busy), 64'(1));
      build_exp(g, get_pl(g));
      if (!keep_req) req = '0;
      // Requester may change its payload once acked.
      if (g == 0) pl0 = rand_pl(); else pl1 = rand_pl();
      idx     = 0;
      cyc     = 0;
      stalled = 1'b0;
      prev    = '0;
      while (idx < FRAME && cyc < 3000) begin
         if (stalled) check("stall_byte", 64'(tx_byte), 64'(prev));
         check("tx_valid", 64'(tx_valid), 64'(1));
         check("tx_byte", 64'(tx_byte), 64'(exp_q[idx]));
         check("busy", 64'(busy), 64'(1));
         check("done_low", 64'(done), 64'(0));
         rdy      = ($urandom_range(0, 99) < duty);
         tx_ready = rdy;
         if (idx == 7) req = req | mid_mask;
         stalled = tx_valid && !rdy;
         prev    = tx_byte;
         if (tx_valid && rdy) idx++;
         @(negedge clock);
         cyc++;
         if (idx < FRAME) check("ack_low", 64'(ack), 64'(0));
      end
      check("frame_len", 64'(idx), 64'(FRAME));
      check("done_pulse", 64'(done), 64'(1));
      check("busy_end", 64'(busy), 64'(0));
      check("valid_gap", 64'(tx_valid), 64'(0));
      check("ack_end", 64'(ack), 64'(0));
      tx_ready  = 1'b0;
      model_ptr = (g + 1) % NR;
   endtask

   initial begin
      logic [PB-1:0] p1;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_ack", 64'(ack), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(tx_valid), 64'(0));
      check("rst_byte", 64'(tx_byte), 64'(0));
      reset = 1'b0;
      @(negedge clock);

      // 1: counting pattern from requester 0, UART always ready
      p1 = '0;
      for (int k = 0; k < 20; k++) p1[k*8 +: 8] = 8'(21 - k);
      p1[161:160] = 2'b01;
      pl0 = p1;
      run_frame(2'b01, 100, 1'b0, 2'b00);

      // 5: reset during DATA byte 10 of a requester-1 frame
      pl1 = rand_pl();
      req = 2'b10;
      @(negedge clock);
      check("s5_ack", 64'(ack), 64'(2'b10));
      build_exp(1, pl1);
      req      = '0;
      tx_ready = 1'b1;
      repeat (12) @(negedge clock);
      check("s5_byte10", 64'(tx_byte), 64'(exp_q[12]));
      reset    = 1'b1;
      tx_ready = 1'b0;
      @(negedge clock);
      check("s5_valid", 64'(tx_valid), 64'(0));
      check("s5_busy", 64'(busy), 64'(0));
      check("s5_done", 64'(done), 64'(0));
      check("s5_byte", 64'(tx_byte), 64'(0));
      reset = 1'b0;
      model_ptr = 0;
      @(negedge clock);
      check("s5_no_done", 64'(done), 64'(0));
      pl0 = rand_pl();
      pl1 = rand_pl();
      run_frame(2'b11, 100, 1'b0, 2'b00);
      run_frame(2'b10, 100, 1'b0, 2'b00);

      // 2: both held for three frames
      run_frame(2'b11, 100, 1'b1, 2'b00);
      run_frame(2'b11, 100, 1'b1, 2'b00);
      run_frame(2'b11, 100, 1'b0, 2'b00);

      // 3: scenario 1 payload with a stalling UART
      pl0 = p1;
      run_frame(2'b01, 30, 1'b0, 2'b00);

      // 4: all-ones payload
      pl0 = '1;
      run_frame(2'b01, 100, 1'b0, 2'b00);

      // 6: requester 1 raised mid-frame and held until served
      pl0 = rand_pl();
      pl1 = rand_pl();
      run_frame(2'b01, 100, 1'b0, 2'b10);
      run_frame(2'b10, 100, 1'b0, 2'b00);

      // Randomized frames
      for (int n = 0; n < 6; n++) begin
         pl0 = rand_pl();
         pl1 = rand_pl();
         run_frame(NR'($urandom_range(1, 3)), int'($urandom_range(40, 100)), 1'b0, 2'b00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
